control_multiciclo: RTL

Multicycle sequencer for the MIPS-subset datapath. It replaces the single-cycle control/ALU-op decoder pair with a Moore FSM (plus two Mealy strobes) that steps each instruction through fetch, decode, execute, memory and write-back, so one shared memory and one ALU serve every phase. It sits beside the instruction register and drives every datapath mux select and write enable. It stalls on a memory ready handshake, traps illegal opcodes and counts retired instructions.

---
 rtl/control_multiciclo_pkg.sv | 66 ++++++
 rtl/control_multiciclo_decodif.sv | 71 +++++++
 rtl/control_multiciclo.sv | 106 ++++++++++
 3 files changed

// File: rtl/control_multiciclo_pkg.sv
// Shared encodings for the multicycle MIPS-subset sequencer.
package defs_multiciclo;

  typedef enum logic [3:0] {
    INICIO  = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXEC    = 4'd7,
    RWB     = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10,
    ADDI_EX = 4'd11,
    ADDI_WB = 4'd12,
    ILEGAL  = 4'd15
  } estado_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] FPC_ALU    = 2'b00;
  localparam logic [1:0] FPC_ALUOUT = 2'b01;
  localparam logic [1:0] FPC_JUMP   = 2'b10;

  localparam logic [1:0] FALUB_B     = 2'b00;
  localparam logic [1:0] FALUB_4     = 2'b01;
  localparam logic [1:0] FALUB_IMM   = 2'b10;
  localparam logic [1:0] FALUB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       EscrPC;
    logic       EscrPCCond;
    logic       IoD;
    logic       LeerMem;
    logic       EscrMem;
    logic       MemaReg;
    logic       EscrIR;
    logic       FuenteALUA;
    logic       EscrReg;
    logic       RegDest;
    logic [1:0] FuentePC;
    logic [1:0] FuenteALUB;
    logic [1:0] ALUOp;
  } ctrl_t;

  // An instruction retires on the edge that returns the FSM to FETCH.
  function automatic logic retira(estado_t e, logic listo);
    case (e)
      MEMWB, RWB, BRANCH, JUMP, ADDI_WB: retira = 1'b1;
      MEMWR:                             retira = listo;
      default:                           retira = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_multiciclo_decodif.sv
// Combinational map from the current state (plus MemListo for the FETCH
// strobes) to every datapath select and enable.
module decodif_salidas_mc
  import defs_multiciclo::*;
(
  input  estado_t estado,
  input  logic    MemListo,
  output ctrl_t   ctrl
);

  // Moore outputs per state; EscrIR/EscrPC in FETCH follow MemListo.
  always_comb begin
    ctrl = '0;
    case (estado)
      FETCH: begin
        ctrl.LeerMem    = 1'b1;
        ctrl.FuenteALUB = FALUB_4;
        ctrl.ALUOp      = ALUOP_ADD;
        ctrl.FuentePC   = FPC_ALU;
        ctrl.EscrIR     = MemListo;
        ctrl.EscrPC     = MemListo;
      end
      DECODE: begin
        ctrl.FuenteALUB = FALUB_IMMSH;
        ctrl.ALUOp      = ALUOP_ADD;
      end
      MEMADR, ADDI_EX: begin
        ctrl.FuenteALUA = 1'b1;
        ctrl.FuenteALUB = FALUB_IMM;
        ctrl.ALUOp      = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.LeerMem = 1'b1;
        ctrl.IoD     = 1'b1;
      end
      MEMWB: begin
        ctrl.EscrReg = 1'b1;
        ctrl.MemaReg = 1'b1;
      end
      MEMWR: begin
        ctrl.EscrMem = 1'b1;
        ctrl.IoD     = 1'b1;
      end
      EXEC: begin
        ctrl.FuenteALUA = 1'b1;
        ctrl.FuenteALUB = FALUB_B;
        ctrl.ALUOp      = ALUOP_FUNCT;
      end
      RWB: begin
        ctrl.EscrReg = 1'b1;
        ctrl.RegDest = 1'b1;
      end
      BRANCH: begin
        ctrl.FuenteALUA = 1'b1;
        ctrl.FuenteALUB = FALUB_B;
        ctrl.ALUOp      = ALUOP_SUB;
        ctrl.EscrPCCond = 1'b1;
        ctrl.FuentePC   = FPC_ALUOUT;
      end
      JUMP: begin
        ctrl.EscrPC   = 1'b1;
        ctrl.FuentePC = FPC_JUMP;
      end
      ADDI_WB: begin
        ctrl.EscrReg = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle sequencer: state register, next-state decode, retired
// instruction counter and sticky illegal-opcode flag.
module control_multiciclo
  import defs_multiciclo::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  instru,
  input  logic        MemListo,
  output logic        EscrPC,
  output logic        EscrPCCond,
  output logic        IoD,
  output logic        LeerMem,
  output logic        EscrMem,
  output logic        MemaReg,
  output logic        EscrIR,
  output logic        FuenteALUA,
  output logic        EscrReg,
  output logic        RegDest,
  output logic [1:0]  FuentePC,
  output logic [1:0]  FuenteALUB,
  output logic [1:0]  ALUOp,
  output logic        Excepcion,
  output logic [3:0]  estado,
  output logic [31:0] ContInstr
);

  estado_t     state_q, state_d;
  logic [31:0] cont_q, cont_d;
  logic        exc_q, exc_d;
  ctrl_t       ctrl;

  // Next state; MemListo only matters in the three memory-wait states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIO:  state_d = FETCH;
      FETCH:   state_d = MemListo ? DECODE : FETCH;
      DECODE: begin
        case (instru)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default:      state_d = ILEGAL;
        endcase
      end
      MEMADR:  state_d = (instru == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MemListo ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = MemListo ? FETCH : MEMWR;
      EXEC:    state_d = RWB;
      RWB:     state_d = FETCH;
      BRANCH:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      ADDI_EX: state_d = ADDI_WB;
      ADDI_WB: state_d = FETCH;
      ILEGAL:  state_d = ILEGAL;
      default: state_d = INICIO;
    endcase
  end

  // Counter and exception flag updates.
  always_comb begin
    cont_d = cont_q + (retira(state_q, MemListo) ? 32'd1 : 32'd0);
    exc_d  = exc_q | ((state_q == DECODE) && (state_d == ILEGAL));
  end

  // State, counter and flag registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INICIO;
      cont_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      exc_q   <= exc_d;
    end
  end

  decodif_salidas_mc u_dec (
    .estado   (state_q),
    .MemListo (MemListo),
    .ctrl     (ctrl)
  );

  assign EscrPC     = ctrl.EscrPC;
  assign EscrPCCond = ctrl.EscrPCCond;
  assign IoD        = ctrl.IoD;
  assign LeerMem    = ctrl.LeerMem;
  assign EscrMem    = ctrl.EscrMem;
  assign MemaReg    = ctrl.MemaReg;
  assign EscrIR     = ctrl.EscrIR;
  assign FuenteALUA = ctrl.FuenteALUA;
  assign EscrReg    = ctrl.EscrReg;
  assign RegDest    = ctrl.RegDest;
  assign FuentePC   = ctrl.FuentePC;
  assign FuenteALUB = ctrl.FuenteALUB;
  assign ALUOp      = ctrl.ALUOp;
  assign Excepcion  = exc_q;
  assign estado     = state_q;
  assign ContInstr  = cont_q;

endmodule
